// File: rtl/sequential_divider.sv
// Purpose : unsigned restoring divider, one quotient bit per clock, switch/button controlled.
// Latency : done and final quotient/remainder valid WIDTH cycles after the run edge.
// Backpres: none; inputs are ignored while busy, and a held run waits in HOLD until released.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   load_dividend         in IDLE, latch S as dividend (Q), clear R and flags
//   run                   in IDLE, start dividing Q by S
//   S                     switch data (dividend or divisor)
//   quotient, remainder   working Q / R registers
//   result                {remainder, quotient}
//   busy                  high while computing
//   done                  result valid
//   div_by_zero           last started division had a zero divisor
module sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_dividend,
  input  logic               run,
  input  logic [WIDTH-1:0]   S,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;

  // After k steps R holds the top k dividend bits mod D, so R < 2^k and the
  // shifted remainder never loses a bit within WIDTH steps.
  always_comb begin
    {r_sh, q_sh} = {r, q} << 1;
    trial        = {1'b0, r_sh} - {1'b0, d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      count       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_dividend) begin
            q           <= S;
            r           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
          end else if (run) begin
            // Q is deliberately kept so a second run divides the previous quotient.
            d           <= S;
            r           <= '0;
            count       <= '0;
            done        <= 1'b0;
            div_by_zero <= (S == '0);
            state       <= ST_CALC;
          end
        end

        ST_CALC: begin
          // trial MSB set means the subtraction went negative: restore.
          if (!trial[WIDTH]) begin
            r <= trial[WIDTH-1:0];
            q <= {q_sh[WIDTH-1:1], 1'b1};
          end else begin
            r <= r_sh;
            q <= {q_sh[WIDTH-1:1], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state <= ST_HOLD;
            done  <= 1'b1;
          end
        end

        ST_HOLD: begin
          // Wait for the button to be released so a held run cannot restart.
          if (!run) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign quotient  = q;
  assign remainder = r;
  assign result    = {r, q};
  assign busy      = (state == ST_CALC);

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
- Unsigned restoring divider, one quotient bit per clock.
- It is the inverse of the lab's add-shift multiplier and uses the same switch/button style of control.
- The dividend is loaded from switch bus S with load_dividend. The divisor is taken from S when run is pressed.
- Outputs the quotient and remainder, with a divide-by-zero flag, for display on the board's hex drivers.

Parameters:
- WIDTH, 8: operand width for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous active-low reset
- load_dividend  input  1  level; in IDLE, latches S as dividend and clears remainder and flags
- run  input  1  level; in IDLE, starts a division using S as divisor
- S  input  WIDTH  switch data (dividend or divisor)
- quotient  output  WIDTH  working/final quotient register Q
- remainder  output  WIDTH  working/final remainder register R
- result  output  2*WIDTH  {remainder, quotient}
- busy  output  1  high while state is CALC
- done  output  1  result valid
- div_by_zero  output  1  last started division had divisor 0

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; Q, R, D (divisor), count, done and div_by_zero all 0. Takes effect immediately, including mid-CALC. The partial result is discarded.
- States: IDLE, CALC, HOLD.
- IDLE, load_dividend=1 at the edge:
  - Q<=S, R<=0, done<=0, div_by_zero<=0.
  - load_dividend has priority over run in the same cycle; run is ignored that cycle.
- IDLE, run=1 and load_dividend=0 at edge t0:
  - D<=S, R<=0, count<=0, done<=0, div_by_zero<=(S==0).
  - State -> CALC.
  - Q is not reloaded. A second run without a load divides the previous quotient (chained division).
- CALC, each edge:
  - {R,Q} <= {R,Q}<<1, giving the shifted remainder R'.
  - trial = {1'b0,R'} - {1'b0,D}, evaluated at WIDTH+1 bits.
  - If trial is non-negative (MSB=0): R<=trial[WIDTH-1:0], Q[0]<=1. Otherwise R keeps R' and Q[0]<=0.
  - count increments; count width is $clog2(WIDTH+1).
  - After WIDTH CALC edges (t1..t8 for WIDTH=8): state -> HOLD, done<=1.
- Latency: done and the final Q/R are visible after edge t0+WIDTH, i.e. 8 cycles after the start edge.
- busy=1 exactly while the state is CALC.
- In CALC, load_dividend, run and S changes are ignored; D is held internally.
- HOLD: stays until run=0, then -> IDLE. A held run button never restarts a division. load_dividend is ignored in HOLD.
- done stays high through HOLD and IDLE until the next load, the next start, or reset.
- Divisor 0: no special path. The algorithm naturally yields Q=all ones and R=dividend, with div_by_zero=1 and the same latency.
- Invariant when done=1: dividend = Q*D + R, and R < D whenever D != 0.
- quotient and remainder expose the working registers at all times. They are only meaningful when done=1, or right after a load (Q=dividend, R=0).

Test Plan:
1. Basic division:
   - Stimulus: reset, load S=200, then run with S=7.
   - Required: busy for exactly 8 cycles; done rises; quotient=28 (0x1C), remainder=4, div_by_zero=0, result=0x041C.
2. Divide by zero:
   - Stimulus: load 0xA5, run with S=0.
   - Required: quotient=0xFF, remainder=0xA5, div_by_zero=1 after 8 cycles.
3. Edge operands:
   - 255/255 -> Q=1, R=0.
   - 5/9 -> Q=0, R=5.
   - 255/1 -> Q=255, R=0.
   - Randomized sweep: 1000 pairs checked against the Q*D+R invariant.
4. Chained division:
   - Stimulus: load 100, run S=3, wait for done, release run.
   - Required: Q=33, R=1.
   - Then run S=4 without reload -> Q=8, R=1.
5. Held and ignored inputs:
   - Hold run high for 50 cycles: only one division occurs; state stays in HOLD.
   - Pulse load_dividend and change S mid-CALC: no effect on the result.
   - Assert load and run together in IDLE: load wins; no division starts.
6. Reset mid-operation:
   - Stimulus: drop reset_n during the 4th CALC cycle.
   - Required: Q, R, busy and done are 0 immediately, without waiting for a clock edge.
   - After release and a fresh load/run, the division completes normally.
